// File: rtl/psram_arbiter.sv
// -----------------------------------------------------------------------------
// psram_arbiter
//
// Two-port round-robin arbiter in front of a PSRAM command engine. Each
// accepted burst is clamped to at most 32 bytes and split into at most two
// engine commands so that no command crosses a PAGE_BYTES page. The requester
// gets a single reqN_done pulse once the whole burst has completed, or once the
// engine has gone silent for TIMEOUT_CYCLES (timeout_err is then set, sticky).
//
// Ports
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   init_done           : engine finished its power-up sequence (used once)
//   reqN_valid/ready    : request handshake, N = 0,1
//   reqN_we/addr/len    : request direction, byte address, length (0 => 32)
//   reqN_done           : one-cycle completion pulse for requester N
//   eng_valid/ready     : command handshake to the engine
//   eng_we/addr/len/src : command payload and owning requester id
//   eng_done            : engine finished the current command
//   busy                : arbiter is not idle in ARB
//   timeout_err         : sticky engine-timeout flag
//
// Handshake semantics (both request ports and the engine port): a transfer
// happens on a rising edge where valid && ready are both high. The sender
// keeps valid and payload stable until then; ready never waits on anything
// other than valid and the arbiter's own state.
// -----------------------------------------------------------------------------
module psram_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int PAGE_BYTES     = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_done,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [21:0] req0_addr,
  input  logic [5:0]  req0_len,
  output logic        req0_done,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [21:0] req1_addr,
  input  logic [5:0]  req1_len,
  output logic        req1_done,
  output logic        eng_valid,
  input  logic        eng_ready,
  output logic        eng_we,
  output logic [21:0] eng_addr,
  output logic [5:0]  eng_len,
  output logic        eng_src,
  input  logic        eng_done,
  output logic        busy,
  output logic        timeout_err
);

  localparam int OFFW = $clog2(PAGE_BYTES);
  localparam logic [OFFW:0] PAGE_W = (OFFW + 1)'(PAGE_BYTES);
  localparam int CNTW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_WAIT_INIT,
    S_ARB,
    S_ISSUE,
    S_WAIT_DONE,
    S_SPLIT,
    S_FINISH
  } state_t;

  state_t          state_q;
  logic            last_gnt_q;
  logic            timeout_err_q;
  logic [CNTW-1:0] cnt_q;
  logic            pend_q;
  logic [21:0]     nxt_addr_q;
  logic [5:0]      nxt_len_q;
  logic            eng_valid_q;
  logic            eng_we_q;
  logic [21:0]     eng_addr_q;
  logic [5:0]      eng_len_q;
  logic            eng_src_q;
  logic            busy_q;
  logic [1:0]      done_q;

  // Arbitration and capture-side chunk computation.
  logic            in_arb;
  logic            win_d;
  logic            xfer_d;
  logic            sel_we_d;
  logic [21:0]     sel_addr_d;
  logic [5:0]      sel_len_d;
  logic [5:0]      len_eff_d;
  logic [OFFW:0]   room_d;
  logic            split_d;

  always_comb begin
    in_arb     = (state_q == S_ARB);
    // On a tie the port that was not granted last wins.
    win_d      = (req0_valid && req1_valid) ? ~last_gnt_q : req1_valid;
    req0_ready = in_arb && req0_valid && !win_d;
    req1_ready = in_arb && req1_valid && win_d;
    xfer_d     = req0_ready || req1_ready;
    sel_we_d   = win_d ? req1_we   : req0_we;
    sel_addr_d = win_d ? req1_addr : req0_addr;
    sel_len_d  = win_d ? req1_len  : req0_len;
    len_eff_d  = (sel_len_d == 6'd0 || sel_len_d > 6'd32) ? 6'd32 : sel_len_d;
    // Bytes left before the end of the page holding the start address.
    room_d     = PAGE_W - {1'b0, sel_addr_d[OFFW-1:0]};
    split_d    = int'(len_eff_d) > int'(room_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_WAIT_INIT;
      last_gnt_q    <= 1'b1;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
      pend_q        <= 1'b0;
      nxt_addr_q    <= '0;
      nxt_len_q     <= '0;
      eng_valid_q   <= 1'b0;
      eng_we_q      <= 1'b0;
      eng_addr_q    <= '0;
      eng_len_q     <= '0;
      eng_src_q     <= 1'b0;
      busy_q        <= 1'b1;
      done_q        <= 2'b00;
    end else begin
      done_q <= 2'b00;
      case (state_q)
        S_WAIT_INIT: begin
          if (init_done) begin
            state_q <= S_ARB;
            busy_q  <= 1'b0;
          end
        end
        S_ARB: begin
          if (xfer_d) begin
            last_gnt_q  <= win_d;
            eng_we_q    <= sel_we_d;
            eng_src_q   <= win_d;
            eng_addr_q  <= sel_addr_d;
            eng_len_q   <= split_d ? 6'(room_d) : len_eff_d;
            // Second chunk starts on the next page; the address wraps at 4 MiB.
            nxt_addr_q  <= sel_addr_d + 22'(room_d);
            nxt_len_q   <= len_eff_d - 6'(room_d);
            pend_q      <= split_d;
            eng_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (eng_ready) begin
            eng_valid_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          // A done arriving on the last allowed cycle still counts as success.
          if (eng_done) begin
            if (pend_q) begin
              state_q <= S_SPLIT;
            end else begin
              state_q <= S_FINISH;
              done_q  <= eng_src_q ? 2'b10 : 2'b01;
            end
          end else if (cnt_q == CNT_MAX) begin
            timeout_err_q <= 1'b1;
            pend_q        <= 1'b0;
            state_q       <= S_FINISH;
            done_q        <= eng_src_q ? 2'b10 : 2'b01;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_SPLIT: begin
          eng_addr_q  <= nxt_addr_q;
          eng_len_q   <= nxt_len_q;
          pend_q      <= 1'b0;
          eng_valid_q <= 1'b1;
          state_q     <= S_ISSUE;
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_ARB;
        end
        default: begin
          eng_valid_q <= 1'b0;
          busy_q      <= 1'b1;
          state_q     <= S_WAIT_INIT;
        end
      endcase
    end
  end

  assign eng_valid   = eng_valid_q;
  assign eng_we      = eng_we_q;
  assign eng_addr    = eng_addr_q;
  assign eng_len     = eng_len_q;
  assign eng_src     = eng_src_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign req0_done   = done_q[0];
  assign req1_done   = done_q[1];

endmodule

// File: tb/tb_psram_arbiter.sv
`timescale 1ns/1ps
module tb_psram_arbiter;

  localparam int TMO  = 16;
  localparam int PAGE = 1024;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        init_done;
  logic        req0_valid, req0_ready, req0_we, req0_done;
  logic [21:0] req0_addr;
  logic [5:0]  req0_len;
  logic        req1_valid, req1_ready, req1_we, req1_done;
  logic [21:0] req1_addr;
  logic [5:0]  req1_len;
  logic        eng_valid, eng_ready, eng_we, eng_src, eng_done;
  logic [21:0] eng_addr;
  logic [5:0]  eng_len;
  logic        busy, timeout_err;

  psram_arbiter #(.TIMEOUT_CYCLES(TMO), .PAGE_BYTES(PAGE)) dut (
    .clk(clk), .reset(reset), .init_done(init_done),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_len(req0_len), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_len(req1_len), .req1_done(req1_done),
    .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_we(eng_we),
    .eng_addr(eng_addr), .eng_len(eng_len), .eng_src(eng_src),
    .eng_done(eng_done), .busy(busy), .timeout_err(timeout_err)
  );

  // ---------------------------------------------------------------- scoreboard
  int errors = 0;
  int checks = 0;
  logic [27:0] exp_q[$];   // expected engine commands {addr, len}
  int model_last;          // port granted most recently
  int dc0 = 0;
  int dc1 = 0;

  always @(negedge clk) begin
    if (req0_done === 1'b1) dc0++;
    if (req1_done === 1'b1) dc1++;
  end

  // Reference model: a burst is clamped to 32 bytes and cut at the page end.
  function automatic void model_chunks(input logic [21:0] addr, input logic [5:0] len);
    int le, off, room;
    logic [21:0] a2;
    exp_q.delete();
    le   = (len == 6'd0 || len > 6'd32) ? 32 : int'(len);
    off  = int'(addr) % PAGE;
    room = PAGE - off;
    if (le > room) begin
      exp_q.push_back({addr, 6'(room)});
      a2 = 22'((int'(addr) + room) % (1 << 22));
      exp_q.push_back({a2, 6'(le - room)});
    end else begin
      exp_q.push_back({addr, 6'(le)});
    end
  endfunction

  // ---------------------------------------------------------------- driver tasks
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_req(input int port, input bit we, input logic [21:0] addr,
                           input logic [5:0] len);
    if (port == 0) begin
      req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_len = len;
    end else begin
      req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_len = len;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; init_done = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    eng_ready = 1'b0; eng_done = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    model_last = 1;
  endtask

  // Waits (bounded) for port's ready, then lets the transfer edge pass.
  task automatic accept(input int port, input string tag);
    int n;
    logic r;
    #1;
    n = 0;
    r = (port == 0) ? req0_ready : req1_ready;
    while (r !== 1'b1 && n < 20) begin
      step();
      r = (port == 0) ? req0_ready : req1_ready;
      n++;
    end
    checks++;
    if (r !== 1'b1) begin
      errors++; $display("FAIL %s ready: got %b want 1", tag, r);
    end
    checks++;
    if (((port == 0) ? req1_ready : req0_ready) !== 1'b0) begin
      errors++; $display("FAIL %s other_ready: got 1 want 0", tag);
    end
    model_last = port;
    step();
    checks++;
    if (eng_valid !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s latency: got eng_valid=%b rdy=%b%b want 1 00", tag, eng_valid,
               req1_ready, req0_ready);
    end
  endtask

  // Plays the engine for every command in exp_q and checks completion.
  task automatic engine_serve(input int port, input bit we, input string tag);
    logic [27:0] exp;
    int n, b0, b1;
    b0 = dc0; b1 = dc1;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      n = 0;
      while (eng_valid !== 1'b1 && n < 10) begin step(); n++; end
      checks++;
      if (eng_valid !== 1'b1) begin
        errors++; $display("FAIL %s eng_valid_wait: got %b want 1", tag, eng_valid);
        exp_q.delete();
        return;
      end
      checks++;
      if ({eng_addr, eng_len} !== exp || eng_we !== we || eng_src !== 1'(port)) begin
        errors++;
        $display("FAIL %s cmd: got addr=%h len=%0d we=%b src=%b want addr=%h len=%0d we=%b src=%0d",
                 tag, eng_addr, eng_len, eng_we, eng_src, exp[27:6], exp[5:0], we, port);
      end
      repeat ($urandom_range(0, 2)) begin
        step();
        checks++;
        if (eng_valid !== 1'b1 || {eng_addr, eng_len} !== exp) begin
          errors++;
          $display("FAIL %s hold: got valid=%b addr=%h len=%0d want 1 %h %0d", tag, eng_valid,
                   eng_addr, eng_len, exp[27:6], exp[5:0]);
        end
      end
      eng_ready = 1'b1;
      step();
      eng_ready = 1'b0;
      checks++;
      if (eng_valid !== 1'b0) begin
        errors++; $display("FAIL %s valid_drop: got %b want 0", tag, eng_valid);
      end
      repeat ($urandom_range(0, 3)) step();
      eng_done = 1'b1;
      step();
      eng_done = 1'b0;
      checks++;
      if (exp_q.size() > 0) begin
        if ({req1_done, req0_done} !== 2'b00) begin
          errors++; $display("FAIL %s early_done: got %b%b want 00", tag, req1_done, req0_done);
        end
      end else if ({req1_done, req0_done} !== ((port == 0) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL %s done: got %b%b want port %0d", tag, req1_done, req0_done, port);
      end
    end
    step();
    checks++;
    if (busy !== 1'b0 || {req1_done, req0_done} !== 2'b00) begin
      errors++;
      $display("FAIL %s back_to_arb: got busy=%b done=%b%b want 0 00", tag, busy, req1_done,
               req0_done);
    end
    checks++;
    if ((dc0 - b0) !== ((port == 0) ? 1 : 0) || (dc1 - b1) !== ((port == 1) ? 1 : 0)) begin
      errors++;
      $display("FAIL %s done_count: got %0d/%0d want port %0d once", tag, dc0 - b0, dc1 - b1, port);
    end
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    step();
    checks++;
    if (eng_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0 ||
        req0_done !== 1'b0 || req1_done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: got valid=%b rdy=%b%b done=%b%b busy=%b want 0 00 00 1",
               eng_valid, req1_ready, req0_ready, req1_done, req0_done, busy);
    end
    checks++;
    if (eng_we !== 1'b0 || eng_addr !== 22'd0 || eng_len !== 6'd0 || eng_src !== 1'b0 ||
        timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: got we=%b addr=%h len=%0d src=%b terr=%b want all 0",
               eng_we, eng_addr, eng_len, eng_src, timeout_err);
    end
    reset = 1'b0;
  endtask

  task automatic test_gating();
    drive_req(0, 0, 22'h000010, 6'd4);
    drive_req(1, 1, 22'h000020, 6'd4);
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1 || eng_valid !== 1'b0) begin
        errors++;
        $display("FAIL gating: got rdy=%b%b busy=%b valid=%b want 00 1 0", req1_ready, req0_ready,
                 busy, eng_valid);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    init_done = 1'b1;
    step(); step();
    init_done = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL init_arb: got busy=%b want 0", busy);
    end
    // Stray engine strobes while idle must not move the arbiter.
    eng_done = 1'b1; eng_ready = 1'b1;
    step();
    eng_done = 1'b0; eng_ready = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || eng_valid !== 1'b0 || {req1_done, req0_done} !== 2'b00) begin
      errors++;
      $display("FAIL idle_strobe: got busy=%b valid=%b done=%b%b want 0 0 00", busy, eng_valid,
               req1_done, req0_done);
    end
  endtask

  task automatic test_single();
    drive_req(0, 0, 22'h000100, 6'd16);
    model_chunks(22'h000100, 6'd16);
    accept(0, "single");
    req0_valid = 1'b0;
    engine_serve(0, 0, "single");
  endtask

  task automatic test_tie_rr();
    int win;
    reset = 1'b1;
    drive_req(0, 0, 22'h000040, 6'd8);
    drive_req(1, 1, 22'h000080, 6'd4);
    init_done = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    model_last = 1;
    for (int i = 0; i < 4; i++) begin
      win = 1 - model_last;
      if (win == 0) model_chunks(22'h000040, 6'd8);
      else          model_chunks(22'h000080, 6'd4);
      accept(win, "tie_rr");
      engine_serve(win, (win == 1), "tie_rr");
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_page_split();
    drive_req(1, 1, 22'h0003F8, 6'd32);
    model_chunks(22'h0003F8, 6'd32);
    accept(1, "page_split");
    req1_valid = 1'b0;
    engine_serve(1, 1, "page_split");
  endtask

  task automatic test_clamp_wrap();
    drive_req(0, 1, 22'h3FFFF0, 6'd0);
    model_chunks(22'h3FFFF0, 6'd0);
    accept(0, "clamp_wrap");
    req0_valid = 1'b0;
    engine_serve(0, 1, "clamp_wrap");
  endtask

  task automatic test_random();
    bit v0, v1, we0, we1;
    logic [21:0] a0, a1;
    logic [5:0] l0, l1;
    int win;
    for (int i = 0; i < 30; i++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      we0 = 1'($urandom_range(0, 1)); we1 = 1'($urandom_range(0, 1));
      a0 = 22'($urandom);
      a1 = ($urandom_range(0, 1) == 1) ? 22'(($urandom & 32'h3FFC00) | (1024 - $urandom_range(1, 40)))
                                       : 22'($urandom);
      l0 = 6'($urandom_range(0, 63)); l1 = 6'($urandom_range(0, 63));
      win = (v0 && v1) ? 1 - model_last : (v1 ? 1 : 0);
      if (v0) drive_req(0, we0, a0, l0);
      if (v1) drive_req(1, we1, a1, l1);
      #1;
      checks++;
      if ({req1_ready, req0_ready} !== ((win == 0) ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL rand_grant: got rdy=%b%b want port %0d (v=%b%b)", req1_ready, req0_ready,
                 win, v1, v0);
      end
      model_last = win;
      if (win == 0) model_chunks(a0, l0);
      else          model_chunks(a1, l1);
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      engine_serve(win, (win == 0) ? we0 : we1, "random");
    end
  endtask

  task automatic test_timeout();
    int b0;
    drive_req(0, 1, 22'h0003F0, 6'd32);
    model_chunks(22'h0003F0, 6'd32);
    accept(0, "timeout");
    req0_valid = 1'b0;
    checks++;
    if ({eng_addr, eng_len} !== exp_q[0]) begin
      errors++;
      $display("FAIL timeout_cmd: got addr=%h len=%0d want %h %0d", eng_addr, eng_len,
               exp_q[0][27:6], exp_q[0][5:0]);
    end
    exp_q.delete();
    b0 = dc0;
    eng_ready = 1'b1;
    step();
    eng_ready = 1'b0;
    for (int k = 0; k < TMO; k++) begin
      checks++;
      if (timeout_err !== 1'b0 || busy !== 1'b1 || req0_done !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait cycle %0d: got terr=%b busy=%b done=%b want 0 1 0", k,
                 timeout_err, busy, req0_done);
      end
      step();
    end
    checks++;
    if (timeout_err !== 1'b1 || req0_done !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fire: got terr=%b done=%b want 1 1", timeout_err, req0_done);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (busy !== 1'b0 || eng_valid !== 1'b0 || timeout_err !== 1'b1) begin
        errors++;
        $display("FAIL timeout_after: got busy=%b valid=%b terr=%b want 0 0 1", busy, eng_valid,
                 timeout_err);
      end
    end
    checks++;
    if (dc0 - b0 !== 1) begin
      errors++; $display("FAIL timeout_done_count: got %0d want 1", dc0 - b0);
    end
  endtask

  task automatic test_reset_mid_burst();
    int b0, b1;
    // Reset while the command is waiting for the engine to finish.
    drive_req(1, 0, 22'h002000, 6'd4);
    accept(1, "rst_wait_done");
    req1_valid = 1'b0;
    eng_ready = 1'b1;
    step();
    eng_ready = 1'b0;
    step();
    b0 = dc0; b1 = dc1;
    reset = 1'b1;
    step();
    checks++;
    if (eng_valid !== 1'b0 || busy !== 1'b1 || timeout_err !== 1'b0 ||
        {req1_done, req0_done} !== 2'b00) begin
      errors++;
      $display("FAIL rst_wait_done: got valid=%b busy=%b terr=%b done=%b%b want 0 1 0 00",
               eng_valid, busy, timeout_err, req1_done, req0_done);
    end
    reset = 1'b0;
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    repeat (4) step();
    checks++;
    if ((dc0 - b0) !== 0 || (dc1 - b1) !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_done: got done counts %0d/%0d busy=%b want 0/0 0", dc0 - b0,
               dc1 - b1, busy);
    end
    // Reset while the command is still being offered.
    drive_req(0, 1, 22'h001234, 6'd8);
    accept(0, "rst_issue");
    req0_valid = 1'b0;
    b0 = dc0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (eng_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_issue: got valid=%b busy=%b want 0 1", eng_valid, busy);
    end
    repeat (4) step();
    checks++;
    if (dc0 - b0 !== 0 || eng_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_issue_after: got done=%0d valid=%b want 0 0", dc0 - b0, eng_valid);
    end
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    reset = 1'b1; init_done = 1'b0;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_len = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_len = '0;
    eng_ready = 1'b0; eng_done = 1'b0;
    model_last = 1;
    test_reset();
    test_gating();
    test_single();
    test_tie_rr();
    test_page_split();
    test_clamp_wrap();
    test_random();
    test_timeout();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psram_arbiter.md
PSRAM_ARBITER -- requirements
Module: psram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum number of cycles to wait for eng_done per engine command.
REQ-002 SHALL have parameter PAGE_BYTES, default 1024, meaning the PSRAM page size; it is a power of two and bursts never cross a page.
REQ-003 SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- init_done  in  1  PSRAM engine has finished its reset/QPI-entry sequence.
- reqN_valid  in  1  (N=0,1) requester N has a pending burst.
- reqN_ready  out  1  request accepted this cycle.
- reqN_we  in  1  1=write, 0=read.
- reqN_addr  in  22  byte address.
- reqN_len  in  6  burst length in bytes.
- reqN_done  out  1  one-cycle pulse when the whole request has completed.
- eng_valid  out  1  command to the PSRAM engine is valid.
- eng_ready  in  1  engine accepts the command.
- eng_we  out  1  command direction.
- eng_addr  out  22  command address.
- eng_len  out  6  command length, 1..32.
- eng_src  out  1  id of the requester that owns the command.
- eng_done  in  1  one-cycle pulse when the engine finishes the command and CE is high.
- busy  out  1  state is not ARB.
- timeout_err  out  1  sticky error flag.

Function
REQ-004 SHALL implement states WAIT_INIT, ARB, ISSUE, WAIT_DONE, SPLIT, FINISH.
REQ-005 SHALL stay in WAIT_INIT, with both reqN_ready low, until init_done=1, then go to ARB; init_done is ignored afterwards.
REQ-006 SHALL drive reqN_ready combinationally high only in ARB, only for the arbitration winner, and only while that port's valid is high; a transfer occurs on valid&&ready.
REQ-007 SHALL arbitrate as follows: a single valid port wins; when both are valid, the port not granted last wins (round-robin); last_gnt resets to 1, so port 0 wins the first tie.
REQ-008 SHALL, on transfer, capture we/addr/len/id into internal registers and update last_gnt; request inputs are ignored after capture.
REQ-009 SHALL compute the effective length as len_eff = reqN_len, except reqN_len=0 or reqN_len>32 is clamped to 32.
REQ-010 SHALL split a burst at the page boundary:
- Let room = PAGE_BYTES - addr[log2(PAGE_BYTES)-1:0].
- If len_eff > room: the first command uses length room; the second uses address addr+room and length len_eff-room.
- Otherwise a single command is issued.
REQ-011 SHALL make addresses wrap modulo 2^22, so a second chunk starting past 0x3FFFFF begins at 0x000000.
REQ-012 SHALL hold eng_valid high in ISSUE with stable eng_we/eng_addr/eng_len/eng_src until eng_ready=1, then move to WAIT_DONE.
REQ-013 SHALL assert eng_valid on the cycle after a transfer (latency 1) and shall never assert it in any state other than ISSUE.
REQ-014 SHALL, in WAIT_DONE on eng_done=1, go to SPLIT when a second chunk is pending and to FINISH otherwise.
REQ-015 SHALL use SPLIT for exactly one cycle to load the second-chunk address and length, then return to ISSUE.
REQ-016 SHALL, in FINISH, pulse reqN_done for the owning id for one cycle, then return to ARB; a new request can be accepted on the next cycle.
REQ-017 SHALL run a WAIT_DONE counter, cleared on entry; when it reaches TIMEOUT_CYCLES-1 without eng_done:
- set timeout_err;
- abandon any remaining chunk;
- go to FINISH, so reqN_done still pulses.
REQ-018 SHALL ignore eng_done outside WAIT_DONE.
REQ-019 SHALL ignore eng_ready outside ISSUE.
REQ-020 SHALL drive busy=0 in ARB and busy=1 in every other state.

Reset
REQ-021 SHALL, on reset=1 at a clock edge, go to WAIT_INIT, clear timeout_err, set last_gnt=1 and clear the timeout counter and pending-chunk flag, regardless of state.
REQ-022 SHALL hold reset values of eng_valid=0, reqN_ready=0, reqN_done=0, busy=1, eng_we=0, eng_addr=0, eng_len=0 and eng_src=0.
REQ-023 SHALL, on reset mid-burst, drop eng_valid on the next cycle and shall not issue a reqN_done pulse for the aborted request.

Verification
REQ-024 SHALL be checked for single request: init_done=1, req0 addr=0x000100, len=16, we=0 -> req0_ready for 1 cycle; eng_valid on the next cycle with addr 0x000100 and len 16; one eng_done -> req0_done one cycle later.
REQ-025 SHALL be checked for tie round-robin: both valid continuously from reset -> grants follow 0,1,0,1, and eng_src matches each grant.
REQ-026 SHALL be checked for page split: req1 addr=0x0003F8, len=32 -> commands (0x0003F8, 8) then (0x000400, 24); exactly one req1_done, after the second eng_done.
REQ-027 SHALL be checked for clamp and wrap: len=0 at addr 0x3FFFF0 -> commands (0x3FFFF0, 16) then (0x000000, 16).
REQ-028 SHALL be checked for timeout: eng_done withheld with TIMEOUT_CYCLES=16 -> timeout_err=1 after 16 cycles in WAIT_DONE, reqN_done pulses, arbiter back in ARB.
REQ-029 SHALL be checked for gating and reset: requests with init_done=0 -> no ready; reset asserted in WAIT_DONE -> eng_valid=0, busy=1, timeout_err=0, and no done pulse.
